// File: rtl/md_pkg.sv
// Shared definitions for the parametrised multiply/divide unit:
// operation encodings, FSM states and the divide-class decode helper.
package md_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'b000,
    MD_MULTU = 3'b001,
    MD_DIV   = 3'b010,
    MD_DIVU  = 3'b011,
    MD_MADD  = 3'b100,
    MD_MADDU = 3'b101,
    MD_MSUB  = 3'b110,
    MD_MSUBU = 3'b111
  } md_op_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  function automatic logic is_div(input logic [2:0] op);
    return (op[2:1] == 2'b01);
  endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational datapath: full-width product, accumulate, and
// truncating signed/unsigned divide with a divide-by-zero indication.
module md_calc import md_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic             dz
);

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic                 sgn_s;
  logic [2*WIDTH-1:0]   ext_a_s;
  logic [2*WIDTH-1:0]   ext_b_s;
  logic [2*WIDTH-1:0]   prod_s;
  logic [2*WIDTH-1:0]   acc_s;
  logic [2*WIDTH-1:0]   res_s;
  logic                 neg_a_s;
  logic                 neg_b_s;
  logic [WIDTH-1:0]     mag_a_s;
  logic [WIDTH-1:0]     mag_b_s;
  logic [WIDTH-1:0]     div_b_s;
  logic [WIDTH-1:0]     q_s;
  logic [WIDTH-1:0]     r_s;
  logic [WIDTH-1:0]     quo_s;
  logic [WIDTH-1:0]     rem_s;

  // Operand conditioning, product/quotient formation and result select
  always_comb begin
    // op bit 0 clear selects the signed flavour of every class
    sgn_s   = ~op[0];
    ext_a_s = sgn_s ? {{WIDTH{src_a[WIDTH-1]}}, src_a} : {ZERO, src_a};
    ext_b_s = sgn_s ? {{WIDTH{src_b[WIDTH-1]}}, src_b} : {ZERO, src_b};
    prod_s  = ext_a_s * ext_b_s;
    acc_s   = {hi, lo};

    // Divide on magnitudes; most-negative / -1 wraps back to most-negative
    neg_a_s = sgn_s & src_a[WIDTH-1];
    neg_b_s = sgn_s & src_b[WIDTH-1];
    mag_a_s = neg_a_s ? (ZERO - src_a) : src_a;
    mag_b_s = neg_b_s ? (ZERO - src_b) : src_b;
    dz      = is_div(op) & (src_b == ZERO);
    div_b_s = (src_b == ZERO) ? ONE : mag_b_s;
    q_s     = mag_a_s / div_b_s;
    r_s     = mag_a_s % div_b_s;
    quo_s   = (neg_a_s ^ neg_b_s) ? (ZERO - q_s) : q_s;
    rem_s   = neg_a_s ? (ZERO - r_s) : r_s;

    res_s = acc_s;
    case (op)
      MD_MULT, MD_MULTU: res_s = prod_s;
      MD_MADD, MD_MADDU: res_s = acc_s + prod_s;
      MD_MSUB, MD_MSUBU: res_s = acc_s - prod_s;
      MD_DIV,  MD_DIVU:  res_s = {rem_s, quo_s};
      default:           res_s = acc_s;
    endcase
    res_hi = res_s[2*WIDTH-1:WIDTH];
    res_lo = res_s[WIDTH-1:0];
  end

endmodule

// File: rtl/md_unit_param.sv
// Multi-cycle multiply/divide unit: IDLE/BUSY FSM, latency counter,
// pending result and the architectural HI/LO registers.
module md_unit_param import md_pkg::*; #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  input  logic [1:0]       hilo_wr,
  input  logic [WIDTH-1:0] wd,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div0
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);
  localparam logic [CNT_W-1:0] MUL_CNT  = CNT_W'(MUL_LAT);
  localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};

  md_state_e        state_r;
  md_state_e        state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] pend_hi_r;
  logic [WIDTH-1:0] pend_lo_r;
  logic             pend_dz_r;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;
  logic             div0_r;
  logic [WIDTH-1:0] calc_hi_s;
  logic [WIDTH-1:0] calc_lo_s;
  logic             calc_dz_s;
  logic             accept_s;
  logic             finish_s;
  logic             mt_s;

  md_calc #(.WIDTH(WIDTH)) u_calc (
    .op     (op),
    .src_a  (src_a),
    .src_b  (src_b),
    .hi     (hi_r),
    .lo     (lo_r),
    .res_hi (calc_hi_s),
    .res_lo (calc_lo_s),
    .dz     (calc_dz_s)
  );

  // Flush kills both a same-cycle launch and an in-flight completion
  assign accept_s = (state_r == MD_IDLE) & start & ~flush;
  assign finish_s = (state_r == MD_BUSY) & ~flush & (cnt_r == CNT_ONE);
  assign mt_s     = (state_r == MD_IDLE) & ~start;

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_r <= MD_IDLE;
    else        state_r <= state_nxt_s;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      MD_IDLE: begin
        if (accept_s) state_nxt_s = MD_BUSY;
        else          state_nxt_s = MD_IDLE;
      end
      MD_BUSY: begin
        if (flush || (cnt_r == CNT_ONE)) state_nxt_s = MD_IDLE;
        else                             state_nxt_s = MD_BUSY;
      end
      default: state_nxt_s = MD_IDLE;
    endcase
  end

  // Latency counter and pending result captured at the accepted start
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r     <= CNT_ZERO;
      pend_hi_r <= ZERO;
      pend_lo_r <= ZERO;
      pend_dz_r <= 1'b0;
    end else if (accept_s) begin
      cnt_r     <= is_div(op) ? DIV_CNT : MUL_CNT;
      pend_hi_r <= calc_hi_s;
      pend_lo_r <= calc_lo_s;
      pend_dz_r <= calc_dz_s;
    end else if ((state_r == MD_BUSY) && !flush) begin
      cnt_r <= cnt_r - CNT_ONE;
    end else begin
      cnt_r <= CNT_ZERO;
    end
  end

  // HI/LO registers: completion write or MTHI/MTLO while idle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_r   <= ZERO;
      lo_r   <= ZERO;
      div0_r <= 1'b0;
    end else begin
      div0_r <= finish_s & pend_dz_r;
      if (finish_s && !pend_dz_r) begin
        hi_r <= pend_hi_r;
        lo_r <= pend_lo_r;
      end else if (mt_s) begin
        if (hilo_wr[1]) hi_r <= wd;
        if (hilo_wr[0]) lo_r <= wd;
      end
    end
  end

  assign busy = (state_r == MD_BUSY);
  assign hi   = hi_r;
  assign lo   = lo_r;
  assign div0 = div0_r;

endmodule
